pc_stack_unit: RTL and testbench

//   Parametrised program-counter unit for the soft processor: sequential

---
 rtl/pc_stack_unit.sv | 102 ++++++++++
 tb/tb_pc_stack_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with jump, relative branch and CALL/RET return stack
module pc_stack_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [2:0]         op,
  input  logic [ADDR_W-1:0]  target,
  output logic [ADDR_W-1:0]  addr,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC   = 3'd0,
    OP_JMP   = 3'd1,
    OP_BRREL = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_HOLD  = 3'd5
  } op_e;

  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0]  addr_inc;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               err_nxt;
  logic               push;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth == '0);
  assign addr_inc    = addr + ADDR_W'(1);
  assign push_idx    = IDX_W'(depth);
  assign pop_idx     = IDX_W'(depth - DEPTH_W'(1));

  always_comb begin
    addr_nxt  = addr;
    depth_nxt = depth;
    err_nxt   = err;
    push      = 1'b0;
    if (enable) begin
      case (op)
        OP_INC:   addr_nxt = addr_inc;
        OP_JMP:   addr_nxt = target;
        // Same-width modular add is identical to adding the sign-extended offset.
        OP_BRREL: addr_nxt = addr + target;
        OP_CALL: begin
          if (stack_full) begin
            err_nxt  = 1'b1;
            addr_nxt = addr_inc;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + DEPTH_W'(1);
            addr_nxt  = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_nxt  = 1'b1;
            addr_nxt = addr_inc;
          end else begin
            depth_nxt = depth - DEPTH_W'(1);
            addr_nxt  = stack_mem[pop_idx];
          end
        end
        OP_HOLD: ;
        default: begin
          err_nxt  = 1'b1;
          addr_nxt = addr_inc;
        end
      endcase
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= addr_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr  <= RESET_ADDR;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      addr  <= addr_nxt;
      depth <= depth_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - scoreboard bench for pc_stack_unit (ADDR_W=8, STACK_DEPTH=4)
module tb_pc_stack_unit;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BRR = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HOLD = 3'd5, RSV6 = 3'd6, RSV7 = 3'd7;

  typedef struct {
    logic [7:0] a;
    logic [2:0] d;
    logic       e;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] op;
  logic [7:0] target;
  logic [7:0] addr;
  logic [2:0] depth;
  logic       stack_full, stack_empty, err;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .target(target),
    .addr(addr), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, expv);
    end
  endtask

  task automatic expect_state(input logic [7:0] ea, input logic [2:0] ed, input logic ee,
                              input string nm);
    exp_t x;
    x.a = ea; x.d = ed; x.e = ee; x.nm = nm;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic en, input logic [2:0] o, input logic [7:0] t,
                      input logic [7:0] ea, input logic [2:0] ed, input logic ee,
                      input string nm);
    @(negedge clk);
    enable = en; op = o; target = t;
    @(posedge clk);
    #1 expect_state(ea, ed, ee, nm);
  endtask

  // Monitor: one expected state per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk(x.nm, "addr",  int'(addr),        int'(x.a));
      chk(x.nm, "depth", int'(depth),       int'(x.d));
      chk(x.nm, "err",   int'(err),         int'(x.e));
      chk(x.nm, "full",  int'(stack_full),  int'(x.d == 3'd4));
      chk(x.nm, "empty", int'(stack_empty), int'(x.d == 3'd0));
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; op = INC; target = 8'h00;
    #1 expect_state(8'h00, 3'd0, 1'b0, "reset");
    #11 reset = 1'b1;

    for (int i = 1; i <= 5; i++) step(1, INC, 8'h00, 8'(i), 0, 0, "inc_seq");

    step(1, JMP,  8'hFE, 8'hFE, 0, 0, "jmp_fe");
    step(1, INC,  8'h00, 8'hFF, 0, 0, "inc_ff");
    step(1, INC,  8'h00, 8'h00, 0, 0, "inc_wrap");
    step(1, JMP,  8'h02, 8'h02, 0, 0, "jmp_02");
    step(1, BRR,  8'hFC, 8'hFE, 0, 0, "brrel_neg");
    step(1, BRR,  8'h05, 8'h03, 0, 0, "brrel_pos");

    step(1, JMP,  8'h10, 8'h10, 0, 0, "jmp_10");
    step(1, CALL, 8'h40, 8'h40, 1, 0, "call_40");
    step(1, CALL, 8'h80, 8'h80, 2, 0, "call_80");
    step(1, RET,  8'h00, 8'h41, 1, 0, "ret_41");
    step(1, RET,  8'h00, 8'h11, 0, 0, "ret_11");

    step(1, JMP,  8'h33, 8'h33, 0, 0, "jmp_33");
    for (int i = 0; i < 3; i++) step(0, JMP, 8'h55, 8'h33, 0, 0, "disabled");
    step(1, HOLD, 8'h55, 8'h33, 0, 0, "hold");
    step(1, RSV7, 8'h55, 8'h34, 0, 1, "rsv7");
    step(1, RSV6, 8'h55, 8'h35, 0, 1, "rsv6");

    step(1, JMP,  8'h70, 8'h70, 0, 1, "jmp_70");
    step(1, CALL, 8'h71, 8'h71, 1, 1, "pre_rst1");
    step(1, CALL, 8'h72, 8'h72, 2, 1, "pre_rst2");
    step(1, CALL, 8'h77, 8'h77, 3, 1, "pre_rst3");
    // Pulse reset entirely between edges; only an asynchronous reset can see it.
    @(negedge clk);
    #1 reset = 1'b0; enable = 1'b1; op = INC; target = 8'h00;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 expect_state(8'h01, 3'd0, 1'b0, "post_reset_inc");

    step(1, JMP,  8'h1C, 8'h1C, 0, 0, "jmp_1c");
    step(1, CALL, 8'hA0, 8'hA0, 1, 0, "fill1");
    step(1, CALL, 8'hA1, 8'hA1, 2, 0, "fill2");
    step(1, CALL, 8'hA2, 8'hA2, 3, 0, "fill3");
    step(1, CALL, 8'h1F, 8'h1F, 4, 0, "fill4");
    step(1, JMP,  8'h20, 8'h20, 4, 0, "jmp_20");
    step(1, CALL, 8'h99, 8'h21, 4, 1, "overflow");
    step(1, RET,  8'h00, 8'hA3, 3, 1, "pop4");
    step(1, RET,  8'h00, 8'hA2, 2, 1, "pop3");
    step(1, RET,  8'h00, 8'hA1, 1, 1, "pop2");
    step(1, RET,  8'h00, 8'h1D, 0, 1, "pop1");
    step(1, RET,  8'h00, 8'h1E, 0, 1, "underflow");
    step(1, HOLD, 8'h00, 8'h1E, 0, 1, "hold_end");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
